// File: rtl/hidden_delta_pkg.sv
// Shared constants, operand widths and FSM encoding for the hidden-layer
// delta sequencer and its shared multiplier.
package hidden_delta_pkg;

  // Network shape and fixed-point format (1.0 = 256).
  localparam int N_OUT = 3;
  localparam int N_HID = 5;
  localparam int FRAC  = 8;

  // Operand widths.
  localparam int MAG_W = 10;  // unsigned Q2.8 magnitudes
  localparam int W_W   = 10;  // signed Q1.8 weights
  localparam int ACC_W = 14;  // signed accumulator
  localparam int SP_W  = 9;   // sigmoid derivative, 0..64
  localparam int X_W   = 9;   // clamped activation, 0..256
  localparam int K_W   = 2;
  localparam int J_W   = 3;

  // Shared multiplier: the A port must carry |acc| (up to 8191) in the
  // scale step, so it is wider than the B port.
  localparam int MUL_A_W = 15;
  localparam int MUL_B_W = 12;
  localparam int MUL_P_W = MUL_A_W + MUL_B_W;
  localparam int MUL_O_W = ACC_W;

  localparam logic [X_W-1:0]          ONE       = 9'd256;
  localparam logic signed [ACC_W-1:0] ACC_MAX   = 14'sd8191;
  localparam logic signed [ACC_W-1:0] ACC_MIN   = -14'sd8191;
  localparam logic [MAG_W-1:0]        DELTA_MAX = 10'd1023;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    SPRIME,
    SCALE,
    DONE
  } state_t;

endpackage

// File: rtl/hidden_delta_mul.sv
// Shared signed multiplier: product, arithmetic shift right by FRAC, then
// saturation to the accumulator range. Purely combinational.
module hidden_delta_mul
  import hidden_delta_pkg::*;
(
  input  logic signed [MUL_A_W-1:0] i_a,
  input  logic signed [MUL_B_W-1:0] i_b,
  output logic signed [MUL_O_W-1:0] o_p
);

  localparam logic signed [MUL_P_W-1:0] P_MAX = MUL_P_W'(ACC_MAX);
  localparam logic signed [MUL_P_W-1:0] P_MIN = MUL_P_W'(ACC_MIN);

  logic signed [MUL_P_W-1:0] w_a_ext;
  logic signed [MUL_P_W-1:0] w_b_ext;
  logic signed [MUL_P_W-1:0] w_prod;
  logic signed [MUL_P_W-1:0] w_shift;

  assign w_a_ext = {{(MUL_P_W-MUL_A_W){i_a[MUL_A_W-1]}}, i_a};
  assign w_b_ext = {{(MUL_P_W-MUL_B_W){i_b[MUL_B_W-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_shift = w_prod >>> FRAC;

  // Clamp the scaled product into the symmetric accumulator range.
  always_comb begin
    if (w_shift > P_MAX)      o_p = ACC_MAX;
    else if (w_shift < P_MIN) o_p = ACC_MIN;
    else                      o_p = w_shift[MUL_O_W-1:0];
  end

endmodule

// File: rtl/hidden_delta_sequencer.sv
// Hidden-layer backprop delta sequencer. One shared multiplier is stepped
// through MAC (x N_OUT), SPRIME and SCALE for each hidden neuron in turn.
module hidden_delta_sequencer
  import hidden_delta_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_OUT*MAG_W-1:0]       delta1_mag,
  input  logic [N_OUT-1:0]             delta1_sign,
  input  logic [N_OUT*N_HID*W_W-1:0]   weight,
  input  logic [N_HID*MAG_W-1:0]       out0_cal,
  output logic                         busy,
  output logic                         done,
  output logic [N_HID*MAG_W-1:0]       delta0,
  output logic [N_HID-1:0]             sign0
);

  localparam logic [K_W-1:0] K_LAST = K_W'(N_OUT - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_HID - 1);
  localparam logic signed [ACC_W:0]     SUM_MAX = (ACC_W+1)'(ACC_MAX);
  localparam logic signed [ACC_W:0]     SUM_MIN = (ACC_W+1)'(ACC_MIN);
  localparam logic signed [MUL_O_W-1:0] M_CLAMP = MUL_O_W'(DELTA_MAX);

  state_t r_state;
  state_t w_state_next;

  // Input snapshot taken on the accept cycle.
  logic [MAG_W-1:0]        r_d1_mag  [N_OUT];
  logic [N_OUT-1:0]        r_d1_sign;
  logic signed [W_W-1:0]   r_w       [N_OUT][N_HID];
  logic [MAG_W-1:0]        r_out0    [N_HID];

  logic [K_W-1:0]          r_k;
  logic [J_W-1:0]          r_j;
  logic signed [ACC_W-1:0] r_acc;
  logic [SP_W-1:0]         r_sp;
  logic [MAG_W-1:0]        r_delta0  [N_HID];
  logic [N_HID-1:0]        r_sign0;

  logic                      w_accept;
  logic signed [MUL_A_W-1:0] w_mag_ext;
  logic signed [W_W-1:0]     w_wsel;
  logic [X_W-1:0]            w_x;
  logic [X_W-1:0]            w_one_minus_x;
  logic [ACC_W-1:0]          w_acc_abs;
  logic signed [MUL_A_W-1:0] w_mul_a;
  logic signed [MUL_B_W-1:0] w_mul_b;
  logic signed [MUL_O_W-1:0] w_mul_p;
  logic signed [ACC_W:0]     w_sum;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic [MAG_W-1:0]          w_m;
  logic                      w_sign;

  assign w_accept = (r_state == IDLE) && start;
  assign busy     = (r_state == MAC) || (r_state == SPRIME) || (r_state == SCALE);
  assign done     = (r_state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state sequencing through the per-neuron step order.
  always_comb begin
    // NOTE: default assigned first so no path leaves the output unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = MAC;
      MAC:     if (r_k == K_LAST) w_state_next = SPRIME;
      SPRIME:  w_state_next = SCALE;
      SCALE:   w_state_next = (r_j == J_LAST) ? DONE : MAC;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Capture all inputs when a start is accepted.
  always_ff @(posedge clk) begin
    // NOTE: the snapshot is pure data, always loaded before use, so it has
    // no reset; only control and visible outputs are reset.
    if (w_accept) begin
      r_d1_sign <= delta1_sign;
      for (int k = 0; k < N_OUT; k++) begin
        r_d1_mag[k] <= delta1_mag[k*MAG_W +: MAG_W];
        for (int j = 0; j < N_HID; j++)
          r_w[k][j] <= weight[(k*N_HID + j)*W_W +: W_W];
      end
      for (int j = 0; j < N_HID; j++)
        r_out0[j] <= out0_cal[j*MAG_W +: MAG_W];
    end
  end

  // Operand sources for each step.
  assign w_mag_ext     = {{(MUL_A_W-MAG_W){1'b0}}, r_d1_mag[r_k]};
  assign w_wsel        = r_w[r_k][r_j];
  assign w_x           = (r_out0[r_j] > 10'd256) ? ONE : r_out0[r_j][X_W-1:0];
  assign w_one_minus_x = ONE - w_x;
  assign w_acc_abs     = r_acc[ACC_W-1] ? -r_acc : r_acc;

  // Shared-multiplier operand mux, selected by state.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      MAC: begin
        w_mul_a = r_d1_sign[r_k] ? -w_mag_ext : w_mag_ext;
        w_mul_b = {{(MUL_B_W-W_W){w_wsel[W_W-1]}}, w_wsel};
      end
      SPRIME: begin
        w_mul_a = {{(MUL_A_W-X_W){1'b0}}, w_x};
        w_mul_b = {{(MUL_B_W-X_W){1'b0}}, w_one_minus_x};
      end
      SCALE: begin
        w_mul_a = {1'b0, w_acc_abs};
        w_mul_b = {{(MUL_B_W-SP_W){1'b0}}, r_sp};
      end
      default: ;
    endcase
  end

  hidden_delta_mul u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

  // Saturating accumulate and output clamp.
  assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_mul_p[MUL_O_W-1], w_mul_p};

  always_comb begin
    if (w_sum > SUM_MAX)      w_acc_next = ACC_MAX;
    else if (w_sum < SUM_MIN) w_acc_next = ACC_MIN;
    else                      w_acc_next = w_sum[ACC_W-1:0];
  end

  assign w_m    = (w_mul_p > M_CLAMP) ? DELTA_MAX : w_mul_p[MAG_W-1:0];
  assign w_sign = r_acc[ACC_W-1] && (w_m != '0);

  // Datapath registers: accumulator, indices, derivative and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_k     <= '0;
      r_j     <= '0;
      r_sp    <= '0;
      r_sign0 <= '0;
      for (int j = 0; j < N_HID; j++) r_delta0[j] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_k   <= '0;
            r_j   <= '0;
          end
        end
        MAC: begin
          r_acc <= w_acc_next;
          r_k   <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
        end
        SPRIME: r_sp <= w_mul_p[SP_W-1:0];
        SCALE: begin
          r_delta0[r_j] <= w_m;
          r_sign0[r_j]  <= w_sign;
          r_acc         <= '0;
          r_k           <= '0;
          if (r_j != J_LAST) r_j <= r_j + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_HID; g++) begin : g_out
    assign delta0[g*MAG_W +: MAG_W] = r_delta0[g];
  end
  assign sign0 = r_sign0;

endmodule

// File: tb/tb_hidden_delta_sequencer.sv
// Self-checking bench for hidden_delta_sequencer: directed cases plus
// randomized runs against an arithmetic reference model.
module tb_hidden_delta_sequencer;

  localparam int NO = 3;
  localparam int NH = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NO*10-1:0]    delta1_mag;
  logic [NO-1:0]       delta1_sign;
  logic [NO*NH*10-1:0] weight;
  logic [NH*10-1:0]    out0_cal;
  logic          busy;
  logic          done;
  logic [NH*10-1:0]    delta0;
  logic [NH-1:0]       sign0;

  // Stimulus in plain integer form; packed onto the ports below.
  int d1m [NO];
  bit d1s [NO];
  int wt  [NO][NH];
  int o0  [NH];

  int exp_d0 [NH];
  bit exp_s0 [NH];
  int prev_d0 [NH];
  bit prev_s0 [NH];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hidden_delta_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .delta1_mag  (delta1_mag),
    .delta1_sign (delta1_sign),
    .weight      (weight),
    .out0_cal    (out0_cal),
    .busy        (busy),
    .done        (done),
    .delta0      (delta0),
    .sign0       (sign0)
  );

  // Pack the integer stimulus onto the DUT buses.
  always_comb begin
    delta1_mag  = '0;
    delta1_sign = '0;
    weight      = '0;
    out0_cal    = '0;
    for (int k = 0; k < NO; k++) begin
      delta1_mag[k*10 +: 10] = d1m[k][9:0];
      delta1_sign[k]         = d1s[k];
      for (int j = 0; j < NH; j++)
        weight[(k*NH + j)*10 +: 10] = wt[k][j][9:0];
    end
    for (int j = 0; j < NH; j++)
      out0_cal[j*10 +: 10] = o0[j][9:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: delta0[j] = sigmoid'(out0[j]) * sum_k delta1[k]*w[k][j].
  function automatic void model();
    int acc, d, p, x, sp, m;
    for (int j = 0; j < NH; j++) begin
      acc = 0;
      for (int k = 0; k < NO; k++) begin
        d   = d1s[k] ? -d1m[k] : d1m[k];
        p   = (d * wt[k][j]) >>> 8;
        acc = acc + p;
        if (acc > 8191)  acc = 8191;
        if (acc < -8191) acc = -8191;
      end
      x  = (o0[j] > 256) ? 256 : o0[j];
      sp = (x * (256 - x)) / 256;
      m  = ((acc < 0 ? -acc : acc) * sp) / 256;
      if (m > 1023) m = 1023;
      exp_d0[j] = m;
      exp_s0[j] = (acc < 0) && (m != 0);
    end
  endfunction

  task automatic set_uniform(input int m0, input int m1, input int m2,
                             input int w, input int o);
    d1m[0] = m0; d1m[1] = m1; d1m[2] = m2;
    for (int k = 0; k < NO; k++) begin
      d1s[k] = 1'b0;
      for (int j = 0; j < NH; j++) wt[k][j] = w;
    end
    for (int j = 0; j < NH; j++) o0[j] = o;
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < NO; k++) begin
      d1m[k] = int'($urandom_range(0, 1023));
      d1s[k] = bit'($urandom_range(0, 1));
      for (int j = 0; j < NH; j++) wt[k][j] = int'($urandom_range(0, 1023)) - 512;
    end
    for (int j = 0; j < NH; j++) o0[j] = int'($urandom_range(0, 320));
  endtask

  task automatic check_outputs(input string tag);
    for (int j = 0; j < NH; j++) begin
      check($sformatf("%s_d0[%0d]", tag, j), 32'(delta0[j*10 +: 10]), 32'(exp_d0[j]));
      check($sformatf("%s_s0[%0d]", tag, j), 32'(sign0[j]), 32'(exp_s0[j]));
    end
    for (int j = 0; j < NH; j++) begin
      prev_d0[j] = exp_d0[j];
      prev_s0[j] = exp_s0[j];
    end
  endtask

  // One full run; optionally scrambles inputs mid-run to prove the snapshot.
  task automatic run_and_check(input string tag, input bit scramble);
    int done_cyc = -1;
    int n_done   = 0;
    int bad      = 0;
    model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 27; cyc++) begin
      if (busy !== (cyc <= 25)) bad++;
      if (done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end else if (done !== 1'b0) bad++;
      if (cyc == 3 && scramble) randomize_inputs();
      if (cyc == 12) begin
        check({tag, "_mid_new_d0[0]"}, 32'(delta0[9:0]), 32'(exp_d0[0]));
        check({tag, "_mid_old_d0[4]"}, 32'(delta0[49:40]), 32'(prev_d0[4]));
        check({tag, "_mid_old_s0[4]"}, 32'(sign0[4]), 32'(prev_s0[4]));
      end
      if (cyc < 27) @(negedge clk);
    end
    check({tag, "_done_cycle"}, done_cyc, 26);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_busy_done_shape"}, bad, 0);
    check_outputs(tag);
  endtask

  initial begin
    int q_done[$];
    int n_done;

    rst   = 1'b1;
    start = 1'b0;
    set_uniform(0, 0, 0, 0, 0);
    for (int j = 0; j < NH; j++) begin
      prev_d0[j] = 0;
      prev_s0[j] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(busy),   0);
    check("reset_done",   32'(done),   0);
    check("reset_delta0", 32'(delta0), 0);
    check("reset_sign0",  32'(sign0),  0);
    rst = 1'b0;

    // Basic positive case: every neuron gives 32.
    set_uniform(256, 0, 0, 128, 128);
    run_and_check("basic", 1'b0);

    // Negative delta1[0]: same magnitudes, all signs set.
    d1s[0] = 1'b1;
    run_and_check("negative", 1'b0);

    // Saturation of the output magnitude.
    set_uniform(1023, 1023, 1023, 511, 128);
    run_and_check("saturate", 1'b0);

    // Activation clamp above 1.0 and at 0.
    set_uniform(256, 0, 0, 128, 128);
    o0[2] = 300;
    run_and_check("clamp_hi", 1'b0);
    o0[2] = 0;
    run_and_check("clamp_zero", 1'b0);

    // Handshake: starts at T+5 and T+26 ignored, start at T+27 accepted.
    set_uniform(256, 0, 0, 128, 128);
    d1s[1] = 1'b1;
    d1m[1] = 100;
    model();
    @(negedge clk); start = 1'b1;
    for (int cyc = 1; cyc <= 54; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) q_done.push_back(cyc);
      start = (cyc == 5 || cyc == 26 || cyc == 27);
    end
    start = 1'b0;
    check("hs_done_count", q_done.size(), 2);
    check("hs_first_done",  (q_done.size() > 0) ? q_done[0] : -1, 26);
    check("hs_second_done", (q_done.size() > 1) ? q_done[1] : -1, 53);
    check("hs_idle_busy", 32'(busy), 0);
    check_outputs("handshake");

    // Reset mid-run at T+12 aborts with no done pulse.
    randomize_inputs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",   32'(busy),   0);
    check("abort_done",   32'(done),   0);
    check("abort_delta0", 32'(delta0), 0);
    check("abort_sign0",  32'(sign0),  0);
    n_done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done !== 1'b0) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", n_done, 0);
    for (int j = 0; j < NH; j++) begin
      prev_d0[j] = 0;
      prev_s0[j] = 1'b0;
    end
    run_and_check("after_abort", 1'b0);

    // Randomized runs, half with inputs scrambled during the run.
    for (int r = 0; r < 8; r++) begin
      randomize_inputs();
      run_and_check($sformatf("rand%0d", r), bit'(r % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
